// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types, constants and helpers for the sequential FP adder/subtractor
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;
    localparam int FP_BIAS  = (1 << (FP_EXP_W - 1)) - 1;
    localparam logic [FP_EXP_W-1:0] FP_EXP_ONES = '1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_SPECIAL,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_PACK,
        ST_DONE
    } fp_state_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Canonical quiet NaN for any format: sign 0, exponent all ones, fraction MSB set.
    function automatic logic [127:0] fp_canon_qnan(input int exp_w, input int man_w);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 128; i++) begin
            if ((i >= man_w - 1) && (i < man_w + exp_w)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - combinational round-to-nearest-even on a normalised mantissa
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic [MAN_W:0] man,
    input  logic [EXP_W:0] exp_in,
    input  logic           g,
    input  logic           r,
    input  logic           s,
    output logic [MAN_W:0] man_out,
    output logic [EXP_W:0] exp_out,
    output logic           inexact
);

    logic             inc;
    logic [MAN_W+1:0] sum;

    // Round up on a guard bit unless it is an exact tie with an even LSB.
    always_comb begin
        inc = g & (r | s | man[0]);
        sum = {1'b0, man} + {{(MAN_W + 1){1'b0}}, inc};
        if (sum[MAN_W+1]) begin
            man_out = sum[MAN_W+1:1];
            exp_out = exp_in + 1'b1;
        end else begin
            man_out = sum[MAN_W:0];
            exp_out = exp_in;
        end
        inexact = g | r | s;
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// rtl/fp_addsub_seq.sv - multi-cycle FP add/sub FSM; FP_ADDSUB_FLAGS_EN enables exception flags
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic                     op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [3:0]               flags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int N     = MAN_W + 4;
    localparam int N1    = MAN_W + 5;
    localparam int CNT_W = $clog2(MAN_W + 4);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(MAN_W + 2);
    localparam logic [EXP_W:0]   EXP_MAX    = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0]   EXP_ONE    = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [127:0]     QNAN_WIDE  = fp_canon_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]     QNAN       = QNAN_WIDE[W-1:0];

    fp_state_t        state;
    logic [W-1:0]     a_r, b_r;
    logic             sa, sb;
    logic [EXP_W:0]   ea, eb;
    logic [N-1:0]     ma, mb;
    logic [CNT_W-1:0] shift_cnt;
    logic             res_sign;
    logic [EXP_W:0]   res_exp;
    logic [N1-1:0]    mant_sum;
    logic [W-1:0]     result_r;
    logic             out_valid_r;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic             special_nan, norm_underflow, pack_ovf;
    logic [MAN_W:0]   rnd_man;
    logic [EXP_W:0]   rnd_exp;
    logic             rnd_inexact;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = out_valid_r;
    assign result    = result_r;

    // Right shift by one, folding everything shifted out into the sticky bit.
    function automatic logic [N-1:0] shr_sticky(input logic [N-1:0] m);
        return {1'b0, m[N-1:2], m[1] | m[0]};
    endfunction

    // Operand classification and the conditions that steer the special/underflow/overflow paths.
    always_comb begin
        a_exp          = a_r[W-2:MAN_W];
        b_exp          = b_r[W-2:MAN_W];
        a_frac         = a_r[MAN_W-1:0];
        b_frac         = b_r[MAN_W-1:0];
        a_nan          = (&a_exp) & (|a_frac);
        b_nan          = (&b_exp) & (|b_frac);
        a_inf          = (&a_exp) & ~(|a_frac);
        b_inf          = (&b_exp) & ~(|b_frac);
        a_zero         = ~(|a_exp);
        b_zero         = ~(|b_exp);
        special_nan    = a_nan | b_nan | (a_inf & b_inf & (a_r[W-1] ^ b_r[W-1]));
        norm_underflow = (mant_sum != '0) && !mant_sum[N1-1] && !mant_sum[N1-2]
                         && (res_exp == EXP_ONE);
        pack_ovf       = (res_exp >= EXP_MAX);
    end

    fp_round_rne #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .man     (mant_sum[MAN_W+3:3]),
        .exp_in  (res_exp),
        .g       (mant_sum[2]),
        .r       (mant_sum[1]),
        .s       (mant_sum[0]),
        .man_out (rnd_man),
        .exp_out (rnd_exp),
        .inexact (rnd_inexact)
    );

    // Main sequencer: one operation at a time from acceptance through to the result handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            a_r         <= '0;
            b_r         <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            ea          <= '0;
            eb          <= '0;
            ma          <= '0;
            mb          <= '0;
            shift_cnt   <= '0;
            res_sign    <= 1'b0;
            res_exp     <= '0;
            mant_sum    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= {b[W-1] ^ op, b[W-2:0]};
                        state <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    sa        <= a_r[W-1];
                    sb        <= b_r[W-1];
                    ea        <= a_zero ? '0 : {1'b0, a_exp};
                    eb        <= b_zero ? '0 : {1'b0, b_exp};
                    ma        <= a_zero ? '0 : {1'b1, a_frac, 3'b000};
                    mb        <= b_zero ? '0 : {1'b1, b_frac, 3'b000};
                    shift_cnt <= '0;
                    state     <= ST_SPECIAL;
                end
                ST_SPECIAL: begin
                    state       <= ST_DONE;
                    out_valid_r <= 1'b1;
                    if (special_nan) begin
                        result_r <= QNAN;
                    end else if (a_inf) begin
                        result_r <= a_r;
                    end else if (b_inf) begin
                        result_r <= b_r;
                    end else if (a_zero && b_zero) begin
                        result_r <= {a_r[W-1] & b_r[W-1], {(W - 1){1'b0}}};
                    end else if (a_zero) begin
                        result_r <= b_r;
                    end else if (b_zero) begin
                        result_r <= a_r;
                    end else begin
                        state       <= ST_ALIGN;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_ALIGN: begin
                    if (ea == eb) begin
                        state <= ST_ADD;
                    end else if (ea < eb) begin
                        ma        <= shr_sticky(ma);
                        ea        <= (shift_cnt == LAST_SHIFT) ? eb : ea + 1'b1;
                        shift_cnt <= shift_cnt + 1'b1;
                    end else begin
                        mb        <= shr_sticky(mb);
                        eb        <= (shift_cnt == LAST_SHIFT) ? ea : eb + 1'b1;
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                ST_ADD: begin
                    res_exp <= ea;
                    if (sa == sb) begin
                        mant_sum <= {1'b0, ma} + {1'b0, mb};
                        res_sign <= sa;
                    end else if (ma >= mb) begin
                        mant_sum <= {1'b0, ma} - {1'b0, mb};
                        res_sign <= sa;
                    end else begin
                        mant_sum <= {1'b0, mb} - {1'b0, ma};
                        res_sign <= sb;
                    end
                    state <= ST_NORM;
                end
                ST_NORM: begin
                    if (mant_sum == '0) begin
                        res_sign <= 1'b0;
                        res_exp  <= '0;
                        state    <= ST_PACK;
                    end else if (mant_sum[N1-1]) begin
                        mant_sum <= {1'b0, mant_sum[N1-1:2], mant_sum[1] | mant_sum[0]};
                        res_exp  <= res_exp + 1'b1;
                        state    <= ST_ROUND;
                    end else if (mant_sum[N1-2]) begin
                        state <= ST_ROUND;
                    end else if (norm_underflow) begin
                        mant_sum <= '0;
                        res_exp  <= '0;
                        state    <= ST_PACK;
                    end else begin
                        mant_sum <= {mant_sum[N1-2:0], 1'b0};
                        res_exp  <= res_exp - 1'b1;
                    end
                end
                ST_ROUND: begin
                    mant_sum <= {1'b0, rnd_man, 3'b000};
                    res_exp  <= rnd_exp;
                    state    <= ST_PACK;
                end
                ST_PACK: begin
                    if (pack_ovf) begin
                        result_r <= {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else begin
                        result_r <= {res_sign, res_exp[EXP_W-1:0], mant_sum[MAN_W+2:3]};
                    end
                    out_valid_r <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FP_ADDSUB_FLAGS_EN
    fp_flags_t flg;

    // Exception flags accumulate alongside the sequencer and are cleared on acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            flg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        flg <= '0;
                    end
                end
                ST_SPECIAL: begin
                    if (special_nan) begin
                        flg.invalid <= 1'b1;
                    end
                end
                ST_NORM: begin
                    if (norm_underflow) begin
                        flg.underflow <= 1'b1;
                        flg.inexact   <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    flg.inexact <= flg.inexact | rnd_inexact;
                end
                ST_PACK: begin
                    if (pack_ovf) begin
                        flg.overflow <= 1'b1;
                        flg.inexact  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign flags = flg;
`else
    logic flags_unused;

    assign flags_unused = rnd_inexact;
    assign flags        = 4'b0;
`endif

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb/tb_fp_addsub_seq.sv - directed self-checking bench for fp_addsub_seq
module tb_fp_addsub_seq;

`ifdef FP_ADDSUB_FLAGS_EN
    localparam logic [3:0] FMASK = 4'hF;
`else
    localparam logic [3:0] FMASK = 4'h0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in, b_in;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic start_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                            input logic vop);
        @(negedge clock);
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a_in     = va;
        b_in     = vb;
        op       = vop;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic run_vec(input string name, input logic [31:0] va, input logic [31:0] vb,
                           input logic vop, input logic [31:0] exp_res,
                           input logic [3:0] exp_flg, input int exp_lat);
        int lat;
        start_op(name, va, vb, vop);
        wait_done(name, lat);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, result, exp_res);
        check({name, " flags"}, 32'(flags), 32'(exp_flg & FMASK));
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        check({name, " released"}, 32'(out_valid), 32'd0);
        check({name, " idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        reset     = 1'b1;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        op        = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'h0);
        check("reset flags", 32'(flags), 32'h0);
        reset = 1'b0;

        run_vec("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 8);
        run_vec("one_minus_one",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 7);
        run_vec("tie_even",       32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 32);
        run_vec("tie_odd",        32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 32);
        run_vec("inf_minus_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 3);
        run_vec("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 8);
        run_vec("1p5_plus_2p5",   32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 4'b0000, 9);
        run_vec("2_minus_1p5",    32'h40000000, 32'h3FC00000, 1'b1, 32'h3F000000, 4'b0000, 11);
        run_vec("1_minus_2",      32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 10);
        run_vec("zero_plus_neg3", 32'h00000000, 32'hC0400000, 1'b0, 32'hC0400000, 4'b0000, 3);
        run_vec("negz_plus_negz", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 3);
        run_vec("nan_operand",    32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 3);
        run_vec("inf_plus_one",   32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 3);
        run_vec("subnorm_flush",  32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 3);
        run_vec("underflow",      32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 7);

        start_op("stall", 32'h3F800000, 32'h3F800000, 1'b0);
        wait_done("stall", lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall result", result, 32'h40000000);
            check("stall flags", 32'(flags), 32'h0);
            check("stall in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        check("stall released", 32'(out_valid), 32'd0);

        start_op("reset_align", 32'h3F800000, 32'h33800000, 1'b0);
        repeat (3) @(negedge clock);
        check("reset_align busy", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("reset_align out_valid", 32'(out_valid), 32'd0);
        check("reset_align in_ready", 32'(in_ready), 32'd1);
        check("reset_align result", result, 32'h0);

        run_vec("after_reset",    32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
